tc_to_sm_serial: RTL

Bit-serial decoder that converts a WIDTH-bit two's-complement word into sign-magnitude form (sign flag plus unsigned magnitude). It is the inverse-direction companion to the team's ripple two's-complement negator: the same invert-and-propagate-carry cell is applied one bit per clock, LSB first, under a start/done handshake. It sits between arithmetic datapaths, which produce two's complement, and display or serial-output logic, which consumes sign-magnitude.

---
 rtl/tc_to_sm_serial.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tc_to_sm_serial.sv
// tc_to_sm_serial
// Bit-serial two's-complement to sign-magnitude decoder.
// The operand is walked LSB first, one bit per clock, through the
// invert-and-propagate-carry cell. Completed results are published in one step,
// so sign/mag/ovf never expose partial values.
module tc_to_sm_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [WIDTH-1:0] mag,
    output logic             ovf
);

    // The counter has one spare bit so that it can hold WIDTH-1 for any legal WIDTH.
    localparam int CW = $clog2(WIDTH) + 1;

    // Count value at which the final (MSB) operand bit is processed.
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    // Magnitude of the most negative operand: 1 followed by zeros.
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    count;
    logic             carry;
    logic             neg;

    logic             accept;
    logic             last_bit;
    logic             bit_a;
    logic             res_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] result_nxt;

    // State register; reset aborts any conversion that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the per-bit conversion cell for the current operand LSB.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        last_bit   = 1'b0;
        bit_a      = operand[0];
        res_bit    = bit_a;
        carry_nxt  = 1'b0;
        result_nxt = {res_bit, result[WIDTH-1:1]};

        // A negative operand is negated by inverting each bit and rippling the +1 carry.
        if (neg) begin
            res_bit   = ~bit_a ^ carry;
            carry_nxt = ~bit_a & carry;
        end
        result_nxt = {res_bit, result[WIDTH-1:1]};

        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (count == LAST_COUNT) begin
                    last_bit  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/result shifting, carry and bit counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand <= '0;
            result  <= '0;
            count   <= '0;
            carry   <= 1'b0;
            neg     <= 1'b0;
        end else if (accept) begin
            operand <= din;
            result  <= '0;
            count   <= '0;
            neg     <= din[WIDTH-1];
            carry   <= din[WIDTH-1];
        end else if (state == SHIFT) begin
            operand <= operand >> 1;
            result  <= result_nxt;
            carry   <= carry_nxt;
            count   <= count + CW'(1);
        end
    end

    // Registered handshake and result outputs; results change only on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            sign <= 1'b0;
            mag  <= '0;
            ovf  <= 1'b0;
        end else begin
            busy <= (state_nxt == SHIFT);
            done <= last_bit;
            if (last_bit) begin
                mag  <= result_nxt;
                sign <= neg;
                ovf  <= neg & (result_nxt == MOST_NEG);
            end
        end
    end

endmodule
